// File: rtl/vga_capture_if.sv
// Pin bundle between the incoming VGA link and the capture block's framebuffer
// write port. The capture block is the master; whoever feeds video and consumes writes is the slave.
interface vga_capture_if;
  logic       hsync_in;
  logic       vsync_in;
  logic [7:0] red_in;
  logic [7:0] green_in;
  logic [7:0] blue_in;
  logic       wr_en;
  logic [9:0] wr_x;
  logic [9:0] wr_y;
  logic [7:0] wr_data;
  logic       locked;
  logic       frame_done;
  logic       sync_err;

  modport master (
    input  hsync_in, vsync_in, red_in, green_in, blue_in,
    output wr_en, wr_x, wr_y, wr_data, locked, frame_done, sync_err
  );

  modport slave (
    output hsync_in, vsync_in, red_in, green_in, blue_in,
    input  wr_en, wr_x, wr_y, wr_data, locked, frame_done, sync_err
  );
endinterface

// File: rtl/vga_capture.sv
// VGA receive side: recovers pixel coordinates from hsync/vsync, qualifies the
// timing with a lock FSM and issues one packed RRRGGGBB framebuffer write per active pixel.
//   state    | meaning
//   UNLOCKED | waiting for a vsync rise to start qualifying frames
//   CHECKING | counting consecutive conforming frames
//   LOCKED   | timing trusted, active pixels are written
module vga_capture #(
  parameter int H_ACTIVE    = 640,
  parameter int H_TOTAL     = 800,
  parameter int H_OFFSET    = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_TOTAL     = 525,
  parameter int V_OFFSET    = 33,
  parameter int LOCK_FRAMES = 2
) (
  input  logic          clock,
  input  logic          reset,
  vga_capture_if.master bus
);
  localparam int GW = $clog2(LOCK_FRAMES + 1);
  localparam logic [10:0]   H_LO   = 11'(H_OFFSET);
  localparam logic [10:0]   H_HI   = 11'(H_OFFSET + H_ACTIVE);
  localparam logic [11:0]   H_PER  = 12'(H_TOTAL);
  localparam logic [9:0]    V_LO   = 10'(V_OFFSET);
  localparam logic [9:0]    V_HI   = 10'(V_OFFSET + V_ACTIVE);
  localparam logic [10:0]   V_PER  = 11'(V_TOTAL);
  localparam logic [9:0]    X_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0]    Y_LAST = 10'(V_ACTIVE - 1);
  localparam logic [GW-1:0] G_LOCK = GW'(LOCK_FRAMES);

  typedef enum logic [1:0] {UNLOCKED, CHECKING, LOCKED} lock_state_t;

  lock_state_t state;
  logic [GW-1:0] good_cnt;

  logic       hs_q, vs_q, hs_prev, vs_prev;
  logic [7:0] red_q, green_q, blue_q;
  logic       h_seen, v_seen;
  logic [10:0] hcnt, hcnt_cur;
  logic [11:0] hcnt_inc;
  logic [9:0]  lcnt, lcnt_cur;
  logic [10:0] lines_seen;
  logic        h_rise, v_rise, line_err, frame_err, err;
  logic        h_act, v_act;
  logic [9:0]  col, row;
  logic [7:0]  pixel;
  logic        unused_bits;

  assign h_rise = hs_q & ~hs_prev;
  assign v_rise = vs_q & ~vs_prev;

  // hcnt_cur/lcnt_cur are the coordinates belonging to the sample held in the input registers
  assign hcnt_inc   = {1'b0, hcnt} + 12'd1;
  assign hcnt_cur   = h_rise ? 11'd0 : ((&hcnt) ? hcnt : hcnt_inc[10:0]);
  assign lcnt_cur   = v_rise ? 10'd0 : ((h_rise && !(&lcnt)) ? lcnt + 10'd1 : lcnt);
  assign lines_seen = {1'b0, lcnt} + {10'd0, h_rise};

  assign line_err  = h_rise & h_seen & (hcnt_inc != H_PER);
  assign frame_err = v_rise & v_seen & (lines_seen != V_PER);
  assign err       = line_err | frame_err;

  assign h_act = (hcnt_cur >= H_LO) && (hcnt_cur < H_HI);
  assign v_act = (lcnt_cur >= V_LO) && (lcnt_cur < V_HI);
  assign col   = hcnt_cur[9:0] - H_LO[9:0];
  assign row   = lcnt_cur - V_LO;
  assign pixel = {red_q[7:5], green_q[7:5], blue_q[7:6]};

  assign unused_bits = ^{red_q[4:0], green_q[4:0], blue_q[5:0]};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      hs_prev <= 1'b1;
      vs_prev <= 1'b1;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
      hcnt    <= '0;
      lcnt    <= '0;
      h_seen  <= 1'b0;
      v_seen  <= 1'b0;
    end else begin
      hs_q    <= bus.hsync_in;
      vs_q    <= bus.vsync_in;
      hs_prev <= hs_q;
      vs_prev <= vs_q;
      red_q   <= bus.red_in;
      green_q <= bus.green_in;
      blue_q  <= bus.blue_in;
      hcnt    <= hcnt_cur;
      lcnt    <= lcnt_cur;
      if (h_rise) h_seen <= 1'b1;
      if (v_rise) v_seen <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= UNLOCKED;
      good_cnt       <= '0;
      bus.locked     <= 1'b0;
      bus.sync_err   <= 1'b0;
      bus.wr_en      <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.wr_x       <= '0;
      bus.wr_y       <= '0;
      bus.wr_data    <= '0;
    end else begin
      bus.sync_err   <= err;
      bus.wr_en      <= 1'b0;
      bus.frame_done <= 1'b0;
      case (state)
        UNLOCKED: begin
          if (v_rise) begin
            state    <= CHECKING;
            good_cnt <= '0;
          end
        end
        CHECKING: begin
          if (err) begin
            state <= UNLOCKED;
          end else if (v_rise) begin
            good_cnt <= good_cnt + GW'(1);
            if (good_cnt + GW'(1) == G_LOCK) begin
              state      <= LOCKED;
              bus.locked <= 1'b1;
            end
          end
        end
        LOCKED: begin
          if (err) begin
            state      <= UNLOCKED;
            bus.locked <= 1'b0;
          end
        end
        default: begin
          state      <= UNLOCKED;
          bus.locked <= 1'b0;
        end
      endcase
      // the erroring sample itself is never written, so writes stop the cycle sync_err shows
      if (state == LOCKED && !err && h_act && v_act) begin
        bus.wr_en      <= 1'b1;
        bus.wr_x       <= col;
        bus.wr_y       <= row;
        bus.wr_data    <= pixel;
        bus.frame_done <= (col == X_LAST) && (row == Y_LAST);
      end
    end
  end
endmodule

// File: tb/tb_vga_capture.sv
// Self-checking bench for vga_capture on a scaled-down raster; expected writes come
// from the generator's own line/pixel geometry, not from the DUT's counters.
module tb_vga_capture;
  localparam int H_ACT  = 16;
  localparam int H_TOT  = 40;
  localparam int H_OFF  = 8;
  localparam int V_ACT  = 8;
  localparam int V_TOT  = 20;
  localparam int V_OFF  = 4;
  localparam int HS_LOW = 8;
  localparam int X0     = HS_LOW + H_OFF;   // pin position of column 0 within a line
  localparam int FULL   = H_ACT * V_ACT;

  logic clock = 1'b0;
  logic reset = 1'b0;

  vga_capture_if bus();

  vga_capture #(
    .H_ACTIVE(H_ACT), .H_TOTAL(H_TOT), .H_OFFSET(H_OFF),
    .V_ACTIVE(V_ACT), .V_TOTAL(V_TOT), .V_OFFSET(V_OFF), .LOCK_FRAMES(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #20 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [31:0] salt = 32'd0;
  int cur_l0 = 0;
  int wr_cnt = 0, fd_cnt = 0, err_cnt = 0;
  int exp_x = 0, exp_y = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Colour driven at line l, pin position p; one fixed pixel carries the packing pattern.
  function automatic logic [23:0] pix(input int p, input int l);
    logic [7:0] r, g, b;
    if (p - X0 == 5 && l - cur_l0 == 7) return 24'hE040C0;
    r = 8'(p * 37 + l * 11 + int'(salt[7:0]));
    g = 8'((p ^ (l * 3)) + int'(salt[15:8]));
    b = 8'(p * 5 + l * 29 + int'(salt[23:16]));
    return {r, g, b};
  endfunction

  function automatic logic [7:0] pack(input logic [23:0] c);
    return {c[23:21], c[15:13], c[7:6]};
  endfunction

  task automatic set_idle();
    bus.hsync_in = 1'b1;
    bus.vsync_in = 1'b1;
    bus.red_in   = 8'd0;
    bus.green_in = 8'd0;
    bus.blue_in  = 8'd0;
  endtask

  task automatic drive(input int l, input int p, input int vs_pos);
    logic [23:0] c;
    c = pix(p, l);
    bus.hsync_in = (p >= HS_LOW);
    bus.vsync_in = !((l == 0 && p >= vs_pos) || l == 1 || (l == 2 && p < vs_pos));
    bus.red_in   = c[23:16];
    bus.green_in = c[15:8];
    bus.blue_in  = c[7:0];
  endtask

  always @(negedge clock) begin
    if (bus.sync_err) err_cnt++;
    if (bus.frame_done) fd_cnt++;
    if (bus.wr_en) begin
      wr_cnt++;
      check("wr_x", 32'(bus.wr_x), 32'(exp_x));
      check("wr_y", 32'(bus.wr_y), 32'(exp_y));
      check("wr_data", 32'(bus.wr_data),
            32'(pack(pix(int'(bus.wr_x) + X0, int'(bus.wr_y) + cur_l0))));
      check("frame_done_at_last", 32'(bus.frame_done),
            32'(exp_x == H_ACT - 1 && exp_y == V_ACT - 1));
      if (bus.wr_x == 10'd5 && bus.wr_y == 10'd7) check("pack_5_7", 32'(bus.wr_data), 32'h0000_00EB);
      if (exp_x == H_ACT - 1) begin
        exp_x = 0;
        exp_y++;
      end else begin
        exp_x++;
      end
    end else begin
      check("frame_done_idle", 32'(bus.frame_done), 32'd0);
    end
  end

  // One generated frame: vsync low on lines 0-1 (edges at pin position vs_pos), hsync low for
  // the first HS_LOW clocks of every line. rst_line >= 0 aborts the frame with a mid-line reset.
  task automatic run_frame(input string tag, input int nlines, input int long_line,
                           input int vs_pos, input int rst_line, input int exp_wr,
                           input int exp_lock_mid, input int exp_lock_end, input int exp_err);
    int len;
    logic lk_mid, lk_end;
    lk_mid  = 1'b0;
    salt    = $urandom;
    cur_l0  = 2 + V_OFF - ((vs_pos < HS_LOW) ? 1 : 0);
    wr_cnt  = 0;
    fd_cnt  = 0;
    err_cnt = 0;
    exp_x   = 0;
    exp_y   = 0;
    for (int l = 0; l < nlines; l++) begin
      len = (l == long_line) ? H_TOT + 1 : H_TOT;
      for (int p = 0; p < len; p++) begin
        drive(l, p, vs_pos);
        if (l == rst_line && p == X0 + 4) begin
          check({tag, ".wr_before_reset"}, 32'(bus.wr_en), 32'd1);
          check({tag, ".lock_before_reset"}, 32'(bus.locked), 32'd1);
          #5 reset = 1'b0;
          #1;
          check({tag, ".wr_en_async"}, 32'(bus.wr_en), 32'd0);
          check({tag, ".locked_async"}, 32'(bus.locked), 32'd0);
          check({tag, ".frame_done_async"}, 32'(bus.frame_done), 32'd0);
          check({tag, ".wr_data_async"}, 32'(bus.wr_data), 32'd0);
          set_idle();
          repeat (3) @(posedge clock);
          #1 reset = 1'b1;
          return;
        end
        @(posedge clock);
        #1;
        if (l == 3 && p == 0) lk_mid = bus.locked;
      end
    end
    lk_end = bus.locked;
    check({tag, ".writes"}, 32'(wr_cnt), 32'(exp_wr));
    check({tag, ".frame_done_count"}, 32'(fd_cnt), 32'((exp_wr == FULL) ? 1 : 0));
    check({tag, ".locked_mid"}, 32'(lk_mid), 32'(exp_lock_mid));
    check({tag, ".locked_end"}, 32'(lk_end), 32'(exp_lock_end));
    check({tag, ".sync_err_count"}, 32'(err_cnt), 32'(exp_err));
  endtask

  initial begin
    set_idle();
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst.wr_en", 32'(bus.wr_en), 32'd0);
    check("rst.wr_x", 32'(bus.wr_x), 32'd0);
    check("rst.wr_y", 32'(bus.wr_y), 32'd0);
    check("rst.wr_data", 32'(bus.wr_data), 32'd0);
    check("rst.locked", 32'(bus.locked), 32'd0);
    check("rst.frame_done", 32'(bus.frame_done), 32'd0);
    check("rst.sync_err", 32'(bus.sync_err), 32'd0);
    reset = 1'b1;

    //        tag            lines      long vs_pos rst  writes lk_mid lk_end errs
    run_frame("f0",          V_TOT,     -1,  0,     -1,  0,     0,     0,     0);
    run_frame("f1",          V_TOT,     -1,  0,     -1,  0,     0,     0,     0);
    run_frame("lock",        V_TOT,     -1,  0,     -1,  FULL,  1,     1,     0);
    run_frame("steady",      V_TOT,     -1,  0,     -1,  FULL,  1,     1,     0);
    run_frame("long_line",   V_TOT,     8,   0,     -1,  4 * H_ACT, 1, 0,     1);
    run_frame("relock_a",    V_TOT,     -1,  0,     -1,  0,     0,     0,     0);
    run_frame("relock_b",    V_TOT,     -1,  0,     -1,  0,     0,     0,     0);
    run_frame("relocked",    V_TOT,     -1,  0,     -1,  FULL,  1,     1,     0);
    run_frame("short_frame", V_TOT - 1, -1,  0,     -1,  FULL,  1,     1,     0);
    run_frame("after_short", V_TOT,     -1,  0,     -1,  0,     0,     0,     1);
    run_frame("rs_a",        V_TOT,     -1,  0,     -1,  0,     0,     0,     0);
    run_frame("rs_b",        V_TOT,     -1,  0,     -1,  0,     0,     0,     0);
    run_frame("rs_lock",     V_TOT,     -1,  0,     -1,  FULL,  1,     1,     0);
    run_frame("reset_mid",   V_TOT,     -1,  0,     8,   0,     0,     0,     0);
    run_frame("co_a",        V_TOT,     -1,  HS_LOW, -1, 0,     0,     0,     0);
    run_frame("co_b",        V_TOT,     -1,  HS_LOW, -1, 0,     0,     0,     0);
    run_frame("co_lock",     V_TOT,     -1,  HS_LOW, -1, FULL,  1,     1,     0);
    run_frame("co_steady",   V_TOT,     -1,  HS_LOW, -1, FULL,  1,     1,     0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_capture.md
Name: vga_capture

Overview:
- Receive side of the 640x480@60 VGA link. Runs on the same 25 MHz pixel clock as the timing generator.
- Recovers pixel coordinates from the incoming hsync, vsync and 8-bit-per-channel RGB, then packs each active pixel back to RRRGGGBB.
- Issues one framebuffer write per active pixel once timing lock is established.
- Used for loopback self-test and for frame grabbing into on-chip memory.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_TOTAL, 800, clocks per line (hsync rise to hsync rise)
- H_OFFSET, 48, clocks from hsync-rise cycle to pixel x=0
- V_ACTIVE, 480, active lines per frame
- V_TOTAL, 525, lines per frame (vsync rise to vsync rise)
- V_OFFSET, 33, hsync rises after vsync-rise cycle before line y=0
- LOCK_FRAMES, 2, consecutive conforming frames required for lock

Ports:
- clock  in  1  25 MHz pixel clock
- reset  in  1  asynchronous, active-low reset
- hsync_in  in  1  horizontal sync, active-low pulse
- vsync_in  in  1  vertical sync, active-low pulse
- red_in  in  8  red channel; only [7:5] used
- green_in  in  8  green channel; only [7:5] used
- blue_in  in  8  blue channel; only [7:6] used
- wr_en  out  1  pixel write strobe, one cycle per pixel
- wr_x  out  10  column of the written pixel, 0..639
- wr_y  out  10  row of the written pixel, 0..479
- wr_data  out  8  packed pixel {red[7:5], green[7:5], blue[7:6]}
- locked  out  1  timing lock indicator
- frame_done  out  1  one-cycle pulse on the write of the last pixel (639,479)
- sync_err  out  1  one-cycle pulse on any timing mismatch

Behaviour:
- Input stage: all five inputs pass through one register stage. All timing below refers to the registered values.
- Edge detect:
  - h_rise = registered hsync is 1 and its previous value was 0.
  - v_rise is defined the same way for vsync.
- Horizontal counter (hcnt, 11 bits):
  - Cleared to 0 on the h_rise cycle.
  - Otherwise increments by 1 per clock, saturating at 2047.
- Horizontal period check: on h_rise, if the pre-clear hcnt+1 != H_TOTAL, this is a line error.
  - Exception: the first h_rise after reset is not checked.
- Active column:
  - A sample is horizontally active when H_OFFSET <= hcnt < H_OFFSET+H_ACTIVE.
  - Its column is x = hcnt - H_OFFSET.
- Line counter (lcnt, 10 bits):
  - Cleared to 0 on the v_rise cycle.
  - Otherwise increments on each h_rise, saturating at 1023.
  - If v_rise and h_rise occur in the same cycle, v_rise wins and lcnt becomes 0.
- Active row:
  - A sample is vertically active when V_OFFSET <= lcnt < V_OFFSET+V_ACTIVE.
  - Its row is y = lcnt - V_OFFSET.
- Frame period check: on v_rise, if lines counted since the previous v_rise != V_TOTAL, this is a frame error.
  - Exception: the first v_rise after reset is not checked.
- Lock FSM, with states UNLOCKED, CHECKING, LOCKED:
  - UNLOCKED -> CHECKING on v_rise; a good-frame count is cleared.
  - CHECKING: each error-free frame (no line or frame error between two v_rises) increments the count. At LOCK_FRAMES the FSM moves to LOCKED.
  - CHECKING: any error returns the FSM to UNLOCKED.
  - LOCKED: any line or frame error returns the FSM to UNLOCKED immediately.
  - locked = 1 only in LOCKED.
- sync_err pulses for one cycle on the cycle after a detected line or frame error, in every FSM state.
- Write output (registered):
  - When locked and the current sample is both horizontally and vertically active, the next cycle has wr_en=1 with wr_x, wr_y and wr_data for that sample.
  - Latency is 2 clocks from input pins to wr_en.
  - wr_x, wr_y and wr_data hold their last values while wr_en=0.
- frame_done asserts together with wr_en when wr_x=639 and wr_y=479.
- Loss of lock mid-frame: wr_en drops on the cycle after the error is registered. No partial-frame recovery; writes resume only after a new lock.
- Reset (async assert, sync release):
  - All outputs are 0.
  - FSM returns to UNLOCKED.
  - Counters are 0.
  - Input registers load 1 for hsync/vsync and 0 for RGB.

Test Plan:
- Drive nominal 640x480 timing (hsync 96 low/48/640/16, vsync 2 low/33/480/10) with a pattern where each pixel's value is derived from its x and y. Required: locked rises at the second v_rise after reset+1 conforming frame (exactly LOCK_FRAMES good frames); then 307200 wr_en pulses per frame; first write at (0,0); frame_done exactly once, at (639,479); wr_data matches the packed pattern.
- Pixel packing: drive red=8'hE0, green=8'h40, blue=8'hC0 on pixel (5,7) while locked. Required: wr_en with wr_x=5, wr_y=7, wr_data=8'hE3 | 8'h08 = 8'hEB.
- Single long line of 801 clocks while locked. Required: sync_err pulses once, locked falls, no further wr_en that frame. Relock after 2 good frames.
- Frame of 524 lines while locked. Required: sync_err at the short v_rise, locked=0, and wr_en silent until relocked.
- Assert reset low mid-line during active writes. Required: wr_en, locked and frame_done go 0 asynchronously, with no wr_en until relock after release.
- Coincident v_rise and h_rise on the same cycle. Required: lcnt restarts at 0 and the next frame's y=0 is written at line V_OFFSET.
